start_cloud_hps_system_button_pio: RTL



---
 rtl/start_cloud_hps_system_button_pio.sv | 135 +++++++++++++
 1 files changed

// File: rtl/start_cloud_hps_system_button_pio.sv
// Avalon-MM input PIO: synchronized, edge-detected inputs with W1C edge capture and maskable IRQ.
// Optional per-bit debounce filter enabled by defining BUTTON_PIO_DEBOUNCE_EN.
module start_cloud_hps_system_button_pio #(
    parameter int WIDTH           = 4,
    parameter int EDGE_TYPE       = 1,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_d;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edges;
    logic [WIDTH-1:0] clr_bits;
    logic [1:0]       settle_cnt;
    logic             settle_done;
    logic             wr;
    logic [31:0]      rd_mux;
    logic             unused_wdata;

    assign unused_wdata = ^writedata;

    function automatic logic [31:0] widen(input logic [WIDTH-1:0] v);
        logic [31:0] r;
        r           = '0;
        r[WIDTH-1:0] = v;
        return r;
    endfunction

    // Input synchronizer
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
        end
    end

`ifdef BUTTON_PIO_DEBOUNCE_EN
    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] db_cnt [WIDTH];

    // A bit is accepted only after it has differed from stable for DEBOUNCE_CYCLES cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            stable <= '0;
            for (int i = 0; i < WIDTH; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync2[i] != stable[i]) begin
                    if (db_cnt[i] == CNT_MAX) begin
                        stable[i] <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end
`else
    assign stable = sync2;
`endif

    // Settle inhibit masks the edges caused by reset-zeroed pipeline registers
    always_ff @(posedge clk) begin
        if (reset) begin
            stable_d   <= '0;
            settle_cnt <= '0;
        end else begin
            stable_d <= stable;
            if (!settle_done) settle_cnt <= settle_cnt + 2'd1;
        end
    end

    assign settle_done = (settle_cnt == 2'd3);

    always_comb begin
        edges = '0;
        if (settle_done) begin
            case (EDGE_TYPE)
                0:       edges = stable & ~stable_d;
                1:       edges = ~stable & stable_d;
                default: edges = (stable & ~stable_d) | (~stable & stable_d);
            endcase
        end
    end

    assign wr       = chipselect && !write_n;
    assign clr_bits = (wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

    always_comb begin
        rd_mux = '0;
        case (address)
            2'd0:    rd_mux = widen(stable);
            2'd2:    rd_mux = widen(irq_mask);
            2'd3:    rd_mux = widen(edge_capture);
            default: rd_mux = '0;
        endcase
    end

    // Register file, IRQ and read port; a new edge wins over a same-cycle clear
    always_ff @(posedge clk) begin
        if (reset) begin
            edge_capture <= '0;
            irq_mask     <= '0;
            readdata     <= '0;
            irq          <= 1'b0;
        end else begin
            edge_capture <= (edge_capture & ~clr_bits) | edges;
            if (wr && address == 2'd2) irq_mask <= writedata[WIDTH-1:0];
            irq      <= |(edge_capture & irq_mask);
            readdata <= rd_mux;
        end
    end

endmodule
